// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the master/FIFO/memory-slave path
// Holds the datapath width shared by the master, async FIFO and mem_slave,
// plus the mem_slave FSM state encoding.
package fifo_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;

endpackage

// File: rtl/mem_slave_ram.sv
// rtl/mem_slave_ram.sv - simple dual-port RAM, sync write, registered read
// Ports:
//   clk      - clock, all flops on rising edge
//   rst_n    - async active-low reset (read register only; array not reset)
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - registered read data; same-edge write returns old contents
module mem_slave_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Both blocks sample on the same edge, so the read sees the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule

// File: rtl/mem_slave.sv
// rtl/mem_slave.sv - pops the master-to-memory FIFO into a local byte RAM
// Ports:
//   clk_mem       - single clock
//   reset_n       - async active-low reset
//   fifo_data_out - FIFO read data, valid the cycle after a pop
//   fifo_empty    - FIFO empty flag (already in clk_mem domain)
//   r_en          - FIFO pop request, one cycle per pop (state-decoded)
//   clear         - sync clear of write pointer and count
//   rd_addr       - readback address
//   rd_data       - registered readback data
//   wr_ptr        - next write address
//   count         - valid words, saturating at DEPTH
//   mem_full      - count == DEPTH
//   busy          - FSM not idle
module mem_slave
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WRAP   = 0
) (
  input  logic              clk_mem,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic              r_en,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              mem_full,
  output logic              busy
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_count;

  logic              w_full;
  logic              w_room;
  logic              w_store;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W:0]   w_base_cnt;
  logic [ADDR_W:0]   w_cnt_post;
  logic              w_room_next;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_room  = !w_full || (WRAP != 0);
  assign w_store = (r_state == ST_STORE);

  // A clear coinciding with a store rebases the in-flight byte to address 0
  // so the popped byte is kept rather than dropped.
  assign w_wr_addr  = clear ? '0 : r_wr_ptr;
  assign w_base_cnt = clear ? '0 : r_count;
  assign w_cnt_post = (w_base_cnt == LP_DEPTH) ? LP_DEPTH : w_base_cnt + 1'b1;
  assign w_room_next = (w_cnt_post != LP_DEPTH) || (WRAP != 0);

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = (!fifo_empty && w_room) ? ST_FETCH : ST_IDLE;
      ST_FETCH: w_state_nxt = ST_STORE;
      ST_STORE: w_state_nxt = (!fifo_empty && w_room_next) ? ST_FETCH : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_store) begin
        // Power-of-two depth: the pointer wraps naturally.
        r_wr_ptr <= w_wr_addr + 1'b1;
        r_count  <= w_cnt_post;
      end else if (clear) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end
    end
  end

  mem_slave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_mem),
    .rst_n   (reset_n),
    .we      (w_store),
    .wr_addr (w_wr_addr),
    .wr_data (fifo_data_out),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign r_en     = (r_state == ST_FETCH);
  assign busy     = (r_state != ST_IDLE);
  assign wr_ptr   = r_wr_ptr;
  assign count    = r_count;
  assign mem_full = w_full;

endmodule

// File: doc/mem_slave.md
# mem_slave

Memory-side consumer of the master-to-memory async FIFO. Runs entirely in the `clk_mem` domain. It pops bytes from the FIFO read port whenever data is present and stores them sequentially into an internal byte RAM. The stored contents are exposed through a registered readback port with fill status. It is the stage directly downstream of the FIFO that the master stage writes.

## Interface
- `DATA_W`, default 8: FIFO and RAM word width.
- `DEPTH`, default 16: RAM words; must be a power of two.
- `ADDR_W`, default 4: equals log2(`DEPTH`).
- `WRAP`, default 0:
  - 0: stop popping when the RAM is full.
  - 1: overwrite the oldest word, circular.

Ports:
- `clk_mem`, in, 1: the single clock. Every flop is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `fifo_data_out`, in, `DATA_W`: FIFO read data. Valid the cycle after the edge that sampled `r_en`=1.
- `fifo_empty`, in, 1: FIFO empty flag, already synchronised to `clk_mem`.
- `r_en`, out, 1: FIFO pop request. Registered; one cycle per pop.
- `clear`, in, 1: synchronous clear of the write pointer and count.
- `rd_addr`, in, `ADDR_W`: readback address.
- `rd_data`, out, `DATA_W`: readback data, registered.
- `wr_ptr`, out, `ADDR_W`: address of the next word to be written.
- `count`, out, `ADDR_W`+1: number of valid words, saturating at `DEPTH`.
- `mem_full`, out, 1: asserted when `count` == `DEPTH`.
- `busy`, out, 1: asserted when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, FETCH, STORE.
- Define `room` = !`mem_full` | `WRAP`.
- IDLE: moves to FETCH when `!fifo_empty & room`.
- FETCH:
  - `r_en` = 1; this is a Moore output decoded from the state register.
  - Always moves to STORE.
- STORE:
  - Captures `fifo_data_out` into `mem[wr_ptr]`.
  - `wr_ptr` increments modulo `DEPTH`.
  - `count` increments, saturating at `DEPTH`.
  - Moves to FETCH if `!fifo_empty & room_next`, otherwise to IDLE. `room_next` is `room` evaluated with the post-write count.
- `WRAP`=0 with the RAM full:
  - Stays in IDLE and issues no `r_en`, so the FIFO backs up and `full` eventually reaches the master.
  - Only `clear` releases this state.
- `WRAP`=1 with the RAM full: writes continue, `wr_ptr` wraps from `DEPTH`-1 to 0, and `count` stays at `DEPTH`.
- `clear`:
  - Sets `wr_ptr` and `count` to 0 at the next edge.
  - The FSM state is unchanged.
  - RAM contents are not erased.
  - If asserted in STORE, the in-flight byte is written to `mem[0]`, giving `wr_ptr`=1 and `count`=1. No popped byte is ever dropped.
- Readback: `rd_data` <= `mem[rd_addr]` on every edge. A same-cycle write to the same address returns the old data (read-before-write).

## Timing
- Reset values: state=IDLE, `r_en`=0, `wr_ptr`=0, `count`=0, `mem_full`=0, `busy`=0, `rd_data`=0. RAM contents are undefined and are not reset.
- Reset mid-operation: an in-flight byte is lost. The FIFO side is reset by the same system reset.
- Pop to store latency:
  - `r_en` is high during cycle N.
  - Data is sampled at the end of cycle N+1.
  - `mem` and `wr_ptr` are updated after edge N+2.
- Sustained throughput is 1 word per 2 cycles (FETCH/STORE alternating).
- `mem_full` and `count` update on the same edge as the write.
- Readback latency is 1 cycle from `rd_addr` to `rd_data`.
- `r_en` is never high for two consecutive cycles. It is never high while `fifo_empty` was 1 at the deciding edge.

## Structure
- A shared package `fifo_pkg` holds:
  - the state encoding constants `ST_IDLE`, `ST_FETCH`, `ST_STORE`;
  - `DATA_W`, shared with the master and FIFO.
- One natural sub-module, `mem_slave_ram`: a simple dual-port RAM with a synchronous write, a synchronous read and read-before-write behaviour.
- The FSM, pointer and counter stay in `mem_slave`.

## Test plan
- Reset, then write 3 bytes 0xA1, 0xB2, 0xC3 into the FIFO:
  - `r_en` pulses exactly 3 times, each 2 cycles apart.
  - `wr_ptr`=3 and `count`=3.
  - Readback at addresses 0, 1, 2 returns A1, B2, C3.
- `WRAP`=0, push 20 bytes 0x00–0x13:
  - 16 are stored and `mem_full`=1.
  - `r_en` stays low; the FIFO holds 4 bytes.
  - Asserting `clear` for 1 cycle drains the remaining 4 to addresses 0–3 (0x10–0x13).
- `WRAP`=1, push 18 bytes 0x00–0x11:
  - `count`=16 and `wr_ptr`=2.
  - `mem[0]`=0x10, `mem[1]`=0x11, `mem[2]`=0x02.
- Assert `clear` during STORE of byte 0x55: `mem[0]`=0x55, `wr_ptr`=1, `count`=1.
- Deassert `reset_n` asynchronously mid-FETCH: all outputs go to 0 immediately, without waiting for a clock edge, and the FSM restarts in IDLE.
- Write to address 5 and read address 5 in the same cycle: `rd_data` returns the old value, and the new value the cycle after.
